// File: rtl/cork_pkg.sv
// Shared definitions for the cork tray counter and the dispenser that consumes its CR/BZ status.
package cork_pkg;
  localparam int CNT_W_DEF      = 5;
  localparam int CAP_DEF        = 20;
  localparam int LOW_THR_DEF    = 5;
  localparam int REFILL_QTY_DEF = 15;
  localparam int INIT_CNT_DEF   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FEED = 2'b01,
    HOLD = 2'b10
  } state_t;
endpackage

// File: rtl/cork_tray_counter_if.sv
// Tray counter bus: station/dispenser inputs, status outputs and the debug FSM state.
// With CORK_STATS_EN defined the bus also carries the total_used and batches statistics.
// Handshake: all inputs are sampled on the rising clock edge; use_cork and operator_fill are
// single-cycle pulses, AD is a level; there is no ready/back-pressure, every pulse is consumed.
interface cork_tray_counter_if #(
  parameter int CNT_W = cork_pkg::CNT_W_DEF
);
  logic             use_cork;
  logic             AD;
  logic             operator_fill;
  logic             CR;
  logic             BZ;
  logic [CNT_W-1:0] count;
  logic             feeding;
  logic             underflow;
  cork_pkg::state_t state;
`ifdef CORK_STATS_EN
  logic [15:0]      total_used;
  logic [7:0]       batches;

  modport master (output use_cork, AD, operator_fill,
                  input  CR, BZ, count, feeding, underflow, state, total_used, batches);
  modport slave  (input  use_cork, AD, operator_fill,
                  output CR, BZ, count, feeding, underflow, state, total_used, batches);
`else
  modport master (output use_cork, AD, operator_fill,
                  input  CR, BZ, count, feeding, underflow, state);
  modport slave  (input  use_cork, AD, operator_fill,
                  output CR, BZ, count, feeding, underflow, state);
`endif
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulse is high in the first cycle d is seen high after being low.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/cork_tray_counter.sv
// Cork tray counter: tracks tray fill, meters refill batches on AD rise, decodes CR/BZ status.
// Optional CORK_STATS_EN adds total_used and batches statistics counters.
module cork_tray_counter
    import cork_pkg::*;
#(
    parameter int CAP        = CAP_DEF,
    parameter int LOW_THR    = LOW_THR_DEF,
    parameter int REFILL_QTY = REFILL_QTY_DEF,
    parameter int INIT_CNT   = INIT_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    cork_tray_counter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] LOW_C    = CNT_W'(LOW_THR);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] QTY_LAST = CNT_W'(REFILL_QTY - 1);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] fed_q;
    logic             underflow_q;
    logic             ad_rise;
    logic             at_cap;
    logic             empty;
    logic             feed_inc;
    logic             dec;
`ifdef CORK_STATS_EN
    logic [15:0]      total_used_q;
    logic [7:0]       batches_q;
`endif

    rise_detect u_ad_rise (
        .clk   (clk),
        .reset (reset),
        .d     (bus.AD),
        .pulse (ad_rise)
    );

    // operator_fill wins over both feeding and taking in the same cycle
    always_comb begin
        at_cap    = (count_q == CAP_C);
        empty     = (count_q == '0);
        feed_inc  = (state_q == FEED) && !at_cap && !bus.operator_fill;
        dec       = bus.use_cork && !empty && !bus.operator_fill;
        count_nxt = count_q;
        if (bus.operator_fill) count_nxt = CAP_C;
        else                   count_nxt = count_q + CNT_W'(feed_inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= INIT_C;
            state_q     <= IDLE;
            fed_q       <= '0;
            underflow_q <= 1'b0;
`ifdef CORK_STATS_EN
            total_used_q <= '0;
            batches_q    <= '0;
`endif
        end else begin
            count_q <= count_nxt;
            if (bus.use_cork && empty && !bus.operator_fill) underflow_q <= 1'b1;
`ifdef CORK_STATS_EN
            if (dec) total_used_q <= total_used_q + 16'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (ad_rise) begin
                        state_q <= FEED;
                        fed_q   <= '0;
`ifdef CORK_STATS_EN
                        batches_q <= batches_q + 8'd1;
`endif
                    end
                end
                FEED: begin
                    // no increment means full tray or hand fill: batch is over either way
                    if (!feed_inc) begin
                        state_q <= HOLD;
                    end else begin
                        fed_q <= fed_q + 1'b1;
                        if (fed_q == QTY_LAST || count_nxt == CAP_C) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.AD) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.CR        = (count_q <= LOW_C);
    assign bus.BZ        = empty;
    assign bus.feeding   = (state_q == FEED);
    assign bus.underflow = underflow_q;
    assign bus.state     = state_q;
`ifdef CORK_STATS_EN
    assign bus.total_used = total_used_q;
    assign bus.batches    = batches_q;
`endif
endmodule

// File: tb/tb_cork_tray_counter.sv
// Bench for cork_tray_counter: directed scenarios plus random traffic against a cork-level model.
module tb_cork_tray_counter;
  import cork_pkg::*;

  localparam int CAP        = 20;
  localparam int LOW_THR    = 5;
  localparam int REFILL_QTY = 15;
  localparam int INIT_CNT   = 0;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   nfeed;

  cork_tray_counter_if bus ();

  cork_tray_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: corks in tray, batch progress as "corks added so far"
  int m_cnt, m_added, m_used, m_batches;
  bit m_batch, m_wait, m_uf, m_ad_prev;

  task automatic model_step(input bit rst, input bit u, input bit a, input bit of);
    bit rise, feed, take;
    if (rst) begin
      m_cnt = INIT_CNT; m_added = 0; m_batch = 0; m_wait = 0; m_uf = 0; m_ad_prev = 0;
      m_used = 0; m_batches = 0;
    end else begin
      rise = a && !m_ad_prev;
      m_ad_prev = a;
      feed = m_batch && !of && (m_cnt < CAP);
      take = u && !of && (m_cnt > 0);
      if (u && !of && m_cnt == 0) m_uf = 1;
      m_cnt = of ? CAP : m_cnt + int'(feed) - int'(take);
      if (take) m_used = (m_used + 1) % 65536;
      if (m_batch) begin
        if (!feed) begin
          m_batch = 0; m_wait = 1;
        end else begin
          m_added++;
          if (m_added == REFILL_QTY || m_cnt == CAP) begin m_batch = 0; m_wait = 1; end
        end
      end else if (m_wait) begin
        if (!a) m_wait = 0;
      end else if (rise) begin
        m_batch = 1; m_added = 0; m_batches = (m_batches + 1) % 256;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    state_t exp_state;
    exp_state = m_batch ? FEED : (m_wait ? HOLD : IDLE);
    check("count",     32'(bus.count),     32'(m_cnt));
    check("CR",        32'(bus.CR),        32'(m_cnt <= LOW_THR));
    check("BZ",        32'(bus.BZ),        32'(m_cnt == 0));
    check("feeding",   32'(bus.feeding),   32'(m_batch));
    check("underflow", 32'(bus.underflow), 32'(m_uf));
    check("state",     32'(bus.state),     32'(exp_state));
`ifdef CORK_STATS_EN
    check("total_used", 32'(bus.total_used), 32'(m_used));
    check("batches",    32'(bus.batches),    32'(m_batches));
`endif
  endtask

  // driver: apply inputs for one cycle, advance the model at the edge, check after it
  task automatic tick(input bit rst, input bit u, input bit a, input bit of);
    reset = rst; bus.use_cork = u; bus.AD = a; bus.operator_fill = of;
    @(posedge clk);
    model_step(rst, u, a, of);
    #1;
    compare_all();
    if (bus.feeding === 1'b1) nfeed++;
  endtask

  initial begin
    bit u, a, of, rst;
    reset = 1'b1; bus.use_cork = 1'b0; bus.AD = 1'b0; bus.operator_fill = 1'b0;
    nfeed = 0;

    // reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_BZ", 32'(bus.BZ), 1);
    check("rst_CR", 32'(bus.CR), 1);

    // hand fill then draw down to the warning threshold
    tick(0, 0, 0, 1);
    check("fill_count", 32'(bus.count), 20);
    for (int i = 0; i < 15; i++) tick(0, 1, 0, 0);
    check("five_count", 32'(bus.count), 5);
    check("five_CR", 32'(bus.CR), 1);
    check("five_BZ", 32'(bus.BZ), 0);
    tick(0, 1, 0, 0);
    check("four_count", 32'(bus.count), 4);

    // count=5, AD held high 30 cycles: exactly one 15-cork batch
    tick(0, 0, 0, 1);
    for (int i = 0; i < 15; i++) tick(0, 1, 0, 0);
    nfeed = 0;
    for (int i = 0; i < 30; i++) tick(0, 0, 1, 0);
    check("hold_state", 32'(bus.state), 32'(HOLD));
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    check("batch15_len", 32'(nfeed), 15);
    check("batch15_count", 32'(bus.count), 20);

    // count=10: batch stops at CAP after 10 feeds
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    nfeed = 0;
    for (int i = 0; i < 15; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    check("batch10_len", 32'(nfeed), 10);
    check("batch10_count", 32'(bus.count), 20);

    // feed with use_cork every cycle: count flat, batch still 15 long
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    nfeed = 0;
    tick(0, 0, 1, 0);
    for (int i = 0; i < 15; i++) tick(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    check("netzero_len", 32'(nfeed), 15);
    check("netzero_count", 32'(bus.count), 10);

    // underflow at empty tray, then reset mid-batch
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("uf_count", 32'(bus.count), 0);
    check("uf_flag", 32'(bus.underflow), 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    check("midrst_count", 32'(bus.count), 32'(INIT_CNT));
    check("midrst_state", 32'(bus.state), 32'(IDLE));
    check("midrst_uf", 32'(bus.underflow), 0);
    tick(0, 0, 0, 0);

    // random traffic
    a = 0;
    for (int i = 0; i < 800; i++) begin
      u   = ($urandom_range(0, 2) == 0);
      of  = !u && ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 5) == 0) a = !a;
      tick(rst, u, a, of);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
